// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: shared constants for the memory-mapped 8-bit timer.
//   - register offsets within the 8-byte window (addr[2:0])
//   - bit positions inside CTRL and STATUS
//   - counter run state
package mmio_timer_pkg;

    // Register offsets
    localparam logic [2:0] OFS_CTRL     = 3'd0;
    localparam logic [2:0] OFS_PRESCALE = 3'd1;
    localparam logic [2:0] OFS_COUNT    = 3'd2;
    localparam logic [2:0] OFS_COMPARE  = 3'd3;
    localparam logic [2:0] OFS_STATUS   = 3'd4;

    // CTRL bit indices
    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_ONESHOT    = 3;

    // STATUS bit indices
    localparam int ST_MATCH = 0;
    localparam int ST_OVF   = 1;

    // Counter run state; RUN is exactly CTRL.EN set
    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

endpackage

// File: rtl/mmio_timer_prescaler.sv
// mmio_timer_prescaler: divides the clock by (prescale+1) while enabled.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   en       in   count enable (timer in RUN)
//   clr      in   restart the division (CTRL/PRESCALE written)
//   prescale in   [7:0] terminal value of pcnt
//   tick     out  one-cycle pulse in the cycle where pcnt == prescale
module mmio_timer_prescaler
    import mmio_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] pcnt_r;

    // tick is combinational so the counter update lands on the same edge
    // that wraps pcnt; with prescale==0 it fires every enabled cycle.
    assign tick = en & (pcnt_r == prescale);

    // Prescale counter: held at 0 when stopped, restarted on clear or tick
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_r <= 8'h00;
        end else if (clr || !en || tick) begin
            pcnt_r <= 8'h00;
        end else begin
            pcnt_r <= pcnt_r + 8'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 8-bit timer responding in an 8-byte window.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   addr      in   [7:0] byte address from MEM stage
//   wdata     in   [7:0] store data
//   MemRead   in   load strobe
//   MemWrite  in   store strobe
//   rdata     out  [7:0] load data, combinational, 0 unless hit & MemRead
//   hit       out  address falls inside the window (strobe independent)
//   irq       out  level interrupt: IRQ_EN & (MATCH | OVF)
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR   = 8'hF0,
    parameter logic [7:0] COMPARE_RST = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       MemRead,
    input  logic       MemWrite,
    output logic [7:0] rdata,
    output logic       hit,
    output logic       irq
);

    logic [3:0] ctrl_r,     ctrl_nxt_s;
    logic [7:0] prescale_r, prescale_nxt_s;
    logic [7:0] count_r,    count_nxt_s;
    logic [7:0] compare_r,  compare_nxt_s;
    logic [1:0] status_r,   status_nxt_s;

    logic [2:0]  ofs_s;
    logic        wr_s;
    logic        tick_s;
    logic        pcnt_clr_s;
    logic        match_set_s;
    logic        ovf_set_s;
    logic        oneshot_stop_s;
    logic [1:0]  w1c_s;
    run_state_e  run_state_s;

    assign hit         = (addr[7:3] == BASE_ADDR[7:3]);
    assign ofs_s       = addr[2:0];
    assign wr_s        = hit & MemWrite;
    assign run_state_s = ctrl_r[CTRL_EN] ? ST_RUN : ST_STOP;
    assign pcnt_clr_s  = wr_s & ((ofs_s == OFS_CTRL) | (ofs_s == OFS_PRESCALE));

    // irq is forced low while reset is asserted, before registers clear
    assign irq = ~reset & ctrl_r[CTRL_IRQ_EN] & (|status_r);

    mmio_timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (run_state_s == ST_RUN),
        .clr      (pcnt_clr_s),
        .prescale (prescale_r),
        .tick     (tick_s)
    );

    // Read mux: zero-latency load data, pre-write value on read+write
    always_comb begin
        rdata = 8'h00;
        if (hit && MemRead) begin
            case (ofs_s)
                OFS_CTRL:     rdata = {4'h0, ctrl_r};
                OFS_PRESCALE: rdata = prescale_r;
                OFS_COUNT:    rdata = count_r;
                OFS_COMPARE:  rdata = compare_r;
                OFS_STATUS:   rdata = {6'b000000, status_r};
                default:      rdata = 8'h00;
            endcase
        end else begin
            rdata = 8'h00;
        end
    end

    // Next-state: tick-driven count update first, CPU writes override after
    always_comb begin
        ctrl_nxt_s     = ctrl_r;
        prescale_nxt_s = prescale_r;
        count_nxt_s    = count_r;
        compare_nxt_s  = compare_r;
        match_set_s    = 1'b0;
        ovf_set_s      = 1'b0;
        oneshot_stop_s = 1'b0;
        w1c_s          = 2'b00;

        if (tick_s) begin
            if (count_r == compare_r) begin
                match_set_s    = 1'b1;
                oneshot_stop_s = ctrl_r[CTRL_ONESHOT];
                if (ctrl_r[CTRL_AUTORELOAD]) begin
                    count_nxt_s = 8'h00;
                end else begin
                    // compare==FF without reload wraps and also flags OVF
                    count_nxt_s = count_r + 8'd1;
                    ovf_set_s   = (count_r == 8'hFF);
                end
            end else if (count_r == 8'hFF) begin
                count_nxt_s = 8'h00;
                ovf_set_s   = 1'b1;
            end else begin
                count_nxt_s = count_r + 8'd1;
            end
        end else begin
            count_nxt_s = count_r;
        end

        if (oneshot_stop_s) begin
            ctrl_nxt_s[CTRL_EN] = 1'b0;
        end else begin
            ctrl_nxt_s[CTRL_EN] = ctrl_r[CTRL_EN];
        end

        if (wr_s) begin
            case (ofs_s)
                OFS_CTRL:     ctrl_nxt_s     = wdata[3:0];
                OFS_PRESCALE: prescale_nxt_s = wdata;
                OFS_COMPARE:  compare_nxt_s  = wdata;
                OFS_STATUS:   w1c_s          = wdata[1:0];
                OFS_COUNT: begin
                    // the CPU value replaces the tick's update and its flags
                    count_nxt_s = wdata;
                    match_set_s = 1'b0;
                    ovf_set_s   = 1'b0;
                end
                default: w1c_s = 2'b00;
            endcase
        end else begin
            w1c_s = 2'b00;
        end

        // set has priority over write-1-to-clear
        status_nxt_s = (status_r & ~w1c_s) | {ovf_set_s, match_set_s};
    end

    // Register file update
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r     <= 4'h0;
            prescale_r <= 8'h00;
            count_r    <= 8'h00;
            compare_r  <= COMPARE_RST;
            status_r   <= 2'b00;
        end else begin
            ctrl_r     <= ctrl_nxt_s;
            prescale_r <= prescale_nxt_s;
            count_r    <= count_nxt_s;
            compare_r  <= compare_nxt_s;
            status_r   <= status_nxt_s;
        end
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped 8-bit timer peripheral that responds on the processor's MEM-stage data bus (addr, wdata, MemRead, MemWrite), as the responder beside ram_256B. It decodes an 8-address window and provides control, prescaler, counter, compare and status registers. It raises a level interrupt on compare match or overflow. The top level selects `rdata` over the RAM output whenever `hit` is high.

## Interface
- BASE_ADDR, 8'hF0: window base; must be 8-aligned; window is BASE_ADDR..BASE_ADDR+7.
- COMPARE_RST, 8'hFF: reset value of COMPARE.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock; this is the already-decided reset.
- addr  in  8  MEM-stage ALU result (byte address).
- wdata  in  8  store data.
- MemRead  in  1  load strobe.
- MemWrite  in  1  store strobe.
- rdata  out  8  load data; combinational.
- hit  out  1  addr[7:3] == BASE_ADDR[7:3]; combinational; independent of strobes.
- irq  out  1  level interrupt.

## Operation
Register offsets are addr[2:0]:
- 0 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN, bit3 ONESHOT. Bits 7:4 read 0.
- 1 PRESCALE.
- 2 COUNT.
- 3 COMPARE.
- 4 STATUS: bit0 MATCH, bit1 OVF. Write-1-to-clear. Bits 7:2 read 0.
- 5–7: read 0; writes ignored.

Bus rules:
- rdata = selected register when hit & MemRead, else 8'h00.
- A write commits at the edge where hit & MemWrite.
- MemRead & MemWrite both high: the write commits and rdata shows the pre-write value.

Counter FSM, two states:
- STOP (EN=0): pcnt is held at 0 and COUNT is frozen.
- RUN (EN=1): pcnt increments each cycle. When pcnt == PRESCALE, a tick fires and pcnt returns to 0. With PRESCALE=0 there is a tick every cycle.

On a tick:
- If COUNT == COMPARE: set MATCH. If AUTORELOAD, COUNT ← 0, else COUNT ← COUNT+1. If ONESHOT, EN ← 0 (back to STOP).
- Else if COUNT == 8'hFF: COUNT ← 0 and set OVF.
- Else COUNT ← COUNT+1.
- If COUNT == COMPARE == 8'hFF without AUTORELOAD: COUNT wraps to 0 and both MATCH and OVF are set.

Other writes:
- Writing CTRL or PRESCALE clears pcnt.
- Writing CTRL.EN 0→1 starts counting from the current COUNT.

irq = IRQ_EN & (MATCH | OVF). It is combinational from registers and stays high until software clears the flags.

Simultaneous events:
- CPU write to COUNT in a tick cycle: the write wins, the tick's COUNT update and flag sets are dropped, and pcnt still resets.
- STATUS write-1-to-clear in the same cycle a flag is set: set wins, flag stays 1.
- ONESHOT match in the same cycle as a CPU write setting EN=1: the CPU write wins.

Reset mid-count: every register returns to its reset value on the next edge. Any tick in that cycle is discarded.

## Timing
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=COMPARE_RST, STATUS=0, pcnt=0.
- Output values under reset: rdata follows decode (0 unless read); irq=0; hit is purely address-derived.
- Load latency: 0 cycles. rdata is valid in the same cycle as MemRead, matching RAM timing into MEMWB.
- Store latency: 1 edge. A read of the same register in the next cycle returns the new value.
- Tick period: PRESCALE+1 cycles. The first tick comes PRESCALE+1 edges after the edge that sets EN.
- Flag to irq: a flag set at edge N drives irq high during cycle N+1.

## Structure
- Package mmio_timer_pkg holds:
  - offset constants: OFS_CTRL, OFS_PRESCALE, OFS_COUNT, OFS_COMPARE, OFS_STATUS;
  - CTRL bit indices: CTRL_EN, CTRL_AUTORELOAD, CTRL_IRQ_EN, CTRL_ONESHOT;
  - STATUS bit indices: ST_MATCH, ST_OVF.
- One sub-module, mmio_timer_prescaler.
  - Inputs: clk, reset, en, clr, prescale[7:0].
  - Output: tick.
  - Contains pcnt.
- The top module holds address decode, the register file and the tick/update logic.

## Test plan
- Reset, then read offsets 0–7 → 00,00,00,FF,00,00,00,00; irq=0. Read at addr 8'h10 → hit=0, rdata=00.
- PRESCALE=0, COMPARE=03, CTRL=05 (EN, IRQ_EN) → COUNT=1,2,3 on successive edges. MATCH sets on the tick at COUNT=3 and irq rises the next cycle. Write STATUS=01 → irq falls.
- PRESCALE=2, COUNT=FE, COMPARE=10, CTRL=01 → COUNT changes every 3 cycles: FF, then 00 with OVF=1.
- CTRL=0B (EN, AUTORELOAD, ONESHOT), COMPARE=02, PRESCALE=0 → counts 1,2, then 0 with MATCH=1 and EN=0. COUNT then stays 0.
- Collisions:
  - Write COUNT=55 in a tick cycle → COUNT reads 55 with no increment.
  - Write STATUS=01 in the same cycle MATCH sets → MATCH reads 1.
- Assert reset while RUN with COUNT=7A → next cycle all registers at reset values, COUNT stays 0.
